// File: rtl/output_conditioner_pkg.sv
// Shared types and parameter checks for the output conditioner.
// Optional build macro: OUTPUT_CONDITIONER_MERGE_EN (see output_conditioner.sv).
package output_conditioner_pkg;

   // Conditioner FSM: IDLE waits for a level change, HOLD keeps the pin stable.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // True when the hold counter can reach holdtime-1 without wrapping.
   function automatic bit holdtime_fits(input int unsigned cw, input int unsigned ht);
      return (ht >= 1) && (ht <= (32'd1 << cw));
   endfunction

endpackage

// File: rtl/output_conditioner_if.sv
// Request handshake and pin-side outputs of the output conditioner.
//
// Handshake: a request transfers in a cycle where req_valid and req_ready are
// both high at the rising clock edge; req_level is sampled only then. The
// master may change req_level freely while req_valid is low, and must hold
// req_valid/req_level until the transfer completes. req_ready depends only on
// conditioner state, never on req_valid.
interface output_conditioner_if #(
   parameter int counterwidth = 4
);
   import output_conditioner_pkg::*;

   logic                    req_valid;
   logic                    req_level;
   logic                    req_ready;
   logic                    pinout;
   logic                    changed;
   logic                    busy;
   state_t                  dbg_state;
   logic [counterwidth-1:0] dbg_count;

   // Core-logic side: offers level requests and observes the pin.
   modport master (
      output req_valid,
      output req_level,
      input  req_ready,
      input  pinout,
      input  changed,
      input  busy,
      input  dbg_state,
      input  dbg_count
   );

   // Conditioner side.
   modport slave (
      input  req_valid,
      input  req_level,
      output req_ready,
      output pinout,
      output changed,
      output busy,
      output dbg_state,
      output dbg_count
   );

endinterface

// File: rtl/output_conditioner_hold_timer.sv
// Hold timer: counts cycles since the last pin change and flags the final
// cycle of the minimum hold. The counter is cleared by start and saturates at
// holdtime-1, so it never wraps.
module hold_timer
   import output_conditioner_pkg::*;
#(
   parameter int counterwidth = 4,
   parameter int holdtime     = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic [counterwidth-1:0] counter,
   output logic                    terminal
);

   localparam logic [counterwidth-1:0] TERM_COUNT = counterwidth'(holdtime - 1);

   if (!holdtime_fits(counterwidth, holdtime)) begin : g_bad_params
      $error("hold_timer: holdtime must be >= 1 and <= 2**counterwidth");
   end

   logic [counterwidth-1:0] count_q;
   logic [counterwidth-1:0] count_d;

   // Next count: clear on start, otherwise step up until the terminal value.
   always_comb begin
      count_d = count_q;
      if (start) begin
         count_d = '0;
      end else if (count_q != TERM_COUNT) begin
         count_d = count_q + counterwidth'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign counter  = count_q;
   assign terminal = (count_q == TERM_COUNT);

endmodule

// File: rtl/output_conditioner.sv
// Output conditioner: turns level-change requests into a registered pin level
// that stays stable for at least holdtime cycles after every change, so a
// debouncing receiver on the far side never misses a transition. One request
// can wait in a pending slot while a hold is running.
//
// Build macro OUTPUT_CONDITIONER_MERGE_EN: when defined, requests are always
// accepted during HOLD and the newest one replaces the pending slot (only the
// final level survives). When undefined, the slot back-pressures and every
// request is applied in order.
module output_conditioner
   import output_conditioner_pkg::*;
#(
   parameter int counterwidth = 4,
   parameter int holdtime     = 6,
   parameter bit initlevel    = 1'b0
) (
   input logic                 clk,
   input logic                 reset,
   output_conditioner_if.slave bus
);

   state_t state_q, state_d;
   logic   pinout_q, pinout_d;
   logic   changed_q, changed_d;
   logic   pend_valid_q, pend_valid_d;
   logic   pend_level_q, pend_level_d;

   logic                    timer_start;
   logic                    terminal;
   logic [counterwidth-1:0] hold_count;
   logic                    req_ready;
   logic                    accept;
   logic                    eff_valid;
   logic                    eff_level;

   hold_timer #(
      .counterwidth (counterwidth),
      .holdtime     (holdtime)
   ) u_hold_timer (
      .clk      (clk),
      .reset    (reset),
      .start    (timer_start),
      .counter  (hold_count),
      .terminal (terminal)
   );

   // Ready and the request that decides the pin at the end of a hold.
   always_comb begin
`ifdef OUTPUT_CONDITIONER_MERGE_EN
      req_ready = 1'b1;
      eff_valid = accept | pend_valid_q;
      eff_level = accept ? bus.req_level : pend_level_q;
`else
      req_ready = (state_q == IDLE) || !pend_valid_q;
      eff_valid = pend_valid_q | accept;
      eff_level = pend_valid_q ? pend_level_q : bus.req_level;
`endif
   end

   assign accept = bus.req_valid & req_ready;

   // FSM next-state, pin level, change pulse and pending slot.
   always_comb begin
      state_d      = state_q;
      pinout_d     = pinout_q;
      changed_d    = 1'b0;
      pend_valid_d = pend_valid_q;
      pend_level_d = pend_level_q;
      timer_start  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && (bus.req_level != pinout_q)) begin
               pinout_d    = bus.req_level;
               changed_d   = 1'b1;
               state_d     = HOLD;
               timer_start = 1'b1;
            end
         end
         HOLD: begin
            if (!terminal) begin
               if (accept) begin
                  pend_valid_d = 1'b1;
                  pend_level_d = bus.req_level;
               end
            end else begin
               pend_valid_d = 1'b0;
               if (eff_valid && (eff_level != pinout_q)) begin
                  pinout_d    = eff_level;
                  changed_d   = 1'b1;
                  timer_start = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset drops any hold and pending request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pinout_q     <= initlevel;
         changed_q    <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_level_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pinout_q     <= pinout_d;
         changed_q    <= changed_d;
         pend_valid_q <= pend_valid_d;
         pend_level_q <= pend_level_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.pinout    = pinout_q;
   assign bus.changed   = changed_q;
   assign bus.busy      = (state_q == HOLD);
   assign bus.dbg_state = state_q;
   assign bus.dbg_count = hold_count;

endmodule

// File: tb/tb_output_conditioner.sv
// Directed bench for output_conditioner: dut0 uses holdtime=6/initlevel=0,
// dut1 uses holdtime=1/initlevel=1 for reset level and back-to-back toggles.
module tb_output_conditioner;
   import output_conditioner_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   output_conditioner_if #(.counterwidth(4)) bus0();
   output_conditioner_if #(.counterwidth(1)) bus1();

   output_conditioner #(.counterwidth(4), .holdtime(6), .initlevel(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   output_conditioner #(.counterwidth(1), .holdtime(1), .initlevel(1'b1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic p, input logic c, input logic b, input logic r);
      check({tag, ".pinout"}, 32'(bus0.pinout), 32'(p));
      check({tag, ".changed"}, 32'(bus0.changed), 32'(c));
      check({tag, ".busy"}, 32'(bus0.busy), 32'(b));
      check({tag, ".ready"}, 32'(bus0.req_ready), 32'(r));
   endtask

   task automatic chk_b(input string tag, input logic p, input logic c, input logic b, input logic r);
      check({tag, ".pinout"}, 32'(bus1.pinout), 32'(p));
      check({tag, ".changed"}, 32'(bus1.changed), 32'(c));
      check({tag, ".busy"}, 32'(bus1.busy), 32'(b));
      check({tag, ".ready"}, 32'(bus1.req_ready), 32'(r));
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: run did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus0.req_valid = 1'b0;
      bus0.req_level = 1'b0;
      bus1.req_valid = 1'b0;
      bus1.req_level = 1'b0;
      reset = 1'b1;

      // Reset held for two edges, then released.
      step();
      step();
      reset = 1'b0;
      chk_b("rst1", 1'b1, 1'b0, 1'b0, 1'b1);
      chk_a("rst0", 1'b0, 1'b0, 1'b0, 1'b1);
      check("rst0.count", 32'(bus0.dbg_count), 32'd0);
      check("rst0.state", 32'(bus0.dbg_state), 32'(IDLE));
      step();
      chk_b("rst1.next", 1'b1, 1'b0, 1'b0, 1'b1);
      chk_a("rst0.next", 1'b0, 1'b0, 1'b0, 1'b1);

      // A: single change 0->1, hold for six cycles, then IDLE.
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b1;
      check("a.ready_idle", 32'(bus0.req_ready), 32'd1);
      step();
      bus0.req_valid = 1'b0;
      chk_a("a.t1", 1'b1, 1'b1, 1'b1, 1'b1);
      check("a.count1", 32'(bus0.dbg_count), 32'd0);
      for (int k = 2; k <= 6; k++) begin
         step();
         chk_a($sformatf("a.t%0d", k), 1'b1, 1'b0, 1'b1, 1'b1);
         check($sformatf("a.count%0d", k), 32'(bus0.dbg_count), 32'(k - 1));
      end
      step();
      chk_a("a.t7", 1'b1, 1'b0, 1'b0, 1'b1);
      check("a.state7", 32'(bus0.dbg_state), 32'(IDLE));
      // Back to 0 for the next test.
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b0;
      step();
      bus0.req_valid = 1'b0;
      chk_a("a.back", 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (6) step();
      chk_a("a.back_idle", 1'b0, 0, 0, 1'b1);

      // B: second request during hold waits in the pending slot.
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b1;
      step();
      bus0.req_valid = 1'b0;
      chk_a("b.t1", 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b0;
      check("b.ready_t2", 32'(bus0.req_ready), 32'd1);
      step();
      bus0.req_valid = 1'b0;
`ifdef OUTPUT_CONDITIONER_MERGE_EN
      chk_a("b.t3", 1'b1, 1'b0, 1'b1, 1'b1);
`else
      chk_a("b.t3", 1'b1, 1'b0, 1'b1, 1'b0);
`endif
      for (int k = 4; k <= 6; k++) begin
         step();
`ifdef OUTPUT_CONDITIONER_MERGE_EN
         chk_a($sformatf("b.t%0d", k), 1'b1, 1'b0, 1'b1, 1'b1);
`else
         chk_a($sformatf("b.t%0d", k), 1'b1, 1'b0, 1'b1, 1'b0);
`endif
      end
      step();
      chk_a("b.t7", 1'b0, 1'b1, 1'b1, 1'b1);
      check("b.count7", 32'(bus0.dbg_count), 32'd0);
      for (int k = 8; k <= 12; k++) begin
         step();
         chk_a($sformatf("b.t%0d", k), 1'b0, 1'b0, 1'b1, 1'b1);
      end
      step();
      chk_a("b.t13", 1'b0, 1'b0, 1'b0, 1'b1);

      // C: same-level request is consumed silently.
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b0;
      check("c.ready", 32'(bus0.req_ready), 32'd1);
      step();
      bus0.req_valid = 1'b0;
      chk_a("c.t1", 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk_a("c.t2", 1'b0, 1'b0, 1'b0, 1'b1);

      // D: reset in the middle of a hold with a pending request.
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b1;
      step();
      bus0.req_valid = 1'b0;
      chk_a("d.t1", 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b0;
      step();
      bus0.req_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_a("d.t4", 1'b0, 1'b0, 1'b0, 1'b1);
      check("d.count4", 32'(bus0.dbg_count), 32'd0);
      chk_b("d.dut1", 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 5; k <= 7; k++) begin
         step();
         chk_a($sformatf("d.t%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b1;
      step();
      bus0.req_valid = 1'b0;
      chk_a("d.after", 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (6) step();
      chk_a("d.after_idle", 1'b1, 1'b0, 1'b0, 1'b1);
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b0;
      step();
      bus0.req_valid = 1'b0;
      repeat (6) step();
      chk_a("d.back_idle", 1'b0, 1'b0, 1'b0, 1'b1);

      // E: requests 1, 0, 1 two cycles apart.
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b1;
      step();
      bus0.req_valid = 1'b0;
      step();
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b0;
      step();
      bus0.req_valid = 1'b0;
      step();
      bus0.req_valid = 1'b1;
      bus0.req_level = 1'b1;
`ifdef OUTPUT_CONDITIONER_MERGE_EN
      check("e.ready_t4", 32'(bus0.req_ready), 32'd1);
      step();
      bus0.req_valid = 1'b0;
      step();
      step();
      chk_a("e.t7", 1'b1, 1'b0, 1'b0, 1'b1);
`else
      check("e.ready_t4", 32'(bus0.req_ready), 32'd0);
      step();
      check("e.ready_t5", 32'(bus0.req_ready), 32'd0);
      step();
      check("e.ready_t6", 32'(bus0.req_ready), 32'd0);
      step();
      chk_a("e.t7", 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      bus0.req_valid = 1'b0;
      chk_a("e.t8", 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) step();
      chk_a("e.t12", 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk_a("e.t13", 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (6) step();
      chk_a("e.t19", 1'b1, 1'b0, 1'b0, 1'b1);
`endif

      // F: holdtime=1 allows a toggle every cycle.
      bus1.req_valid = 1'b1;
      bus1.req_level = 1'b0;
      check("f.ready", 32'(bus1.req_ready), 32'd1);
      step();
      bus1.req_level = 1'b1;
      chk_b("f.t1", 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      bus1.req_level = 1'b0;
      chk_b("f.t2", 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      bus1.req_valid = 1'b0;
      chk_b("f.t3", 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      chk_b("f.t4", 1'b0, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
